// File: rtl/my_dmux_pkg.sv
// Shared types and helpers for the round-robin demux dispatcher.
package my_dmux_pkg;

    // Largest channel count the circular search supports.
    localparam int unsigned MAX_N = 64;

    // Select width for an n-way demux; a single bit at minimum.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Returns the first enabled index in the order ptr, ptr+1, ..., n-1, 0, ...
    // When the mask is empty, the result is ptr. Callers gate on a non-zero mask.
    function automatic int unsigned nxt(input int unsigned ptr, input logic [MAX_N-1:0] mask,
                                        input int unsigned n);
        int unsigned idx;
        logic        found;
        nxt   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && mask[idx]) begin
                    nxt   = idx;
                    found = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/my_dmux_n.sv
// WIDTH-wide 1-to-N demultiplexer. Only the selected slice carries din, and only while en is
// high. Every other slice reads zero.
module my_dmux_n
    import my_dmux_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = sel_w(N)
) (
    input  logic [WIDTH-1:0]   din,
    input  logic [SEL_W-1:0]   sel,
    input  logic               en,
    output logic [N*WIDTH-1:0] dout
);

    for (genvar i = 0; i < N; i++) begin : g_slice
        // Steer din into slice i when it is selected.
        assign dout[i*WIDTH +: WIDTH] = (en && (sel == SEL_W'(i))) ? din : '0;
    end

endmodule

// File: rtl/my_dmux_rr_dispatch.sv
// Round-robin dispatcher. A single-entry holding register buffers each input word. The word is
// steered to the next enabled output channel in circular order. A held word and its target
// stay fixed until that channel's out_ready completes the transfer.
module my_dmux_rr_dispatch
    import my_dmux_pkg::*;
#(
    parameter int unsigned N_OUT = 2,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned SEL_W = sel_w(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_OUT-1:0]       ch_en,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [SEL_W-1:0]       sel,
    output logic [CNT_W-1:0]       dispatch_count
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hold_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [SEL_W-1:0]   tgt_q;
    logic [CNT_W-1:0]   count_q;

    logic [MAX_N-1:0]   en_ext;
    logic [SEL_W-1:0]   nxt_idx;
    logic [SEL_W-1:0]   ptr_after;
    logic               accept;
    logic               xfer;

    assign en_ext  = MAX_N'(ch_en);
    assign nxt_idx = SEL_W'(nxt(32'(ptr_q), en_ext, N_OUT));

    // The pointer wraps explicitly, because N_OUT is not always a power of two.
    assign ptr_after = (nxt_idx == SEL_W'(N_OUT - 1)) ? '0 : nxt_idx + SEL_W'(1);

    // The channel enables only gate acceptance. A held word drains even with ch_en == 0.
    assign xfer     = (state_q == FULL) && out_ready[tgt_q];
    assign in_ready = (|ch_en) && ((state_q == EMPTY) || out_ready[tgt_q]);
    assign accept   = in_valid && in_ready;

    // State register: an accept always leaves the entry full. A lone transfer empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the holding entry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (xfer) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // On each accept, capture the word and its target, then advance the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            ptr_q  <= '0;
            tgt_q  <= '0;
        end else if (accept) begin
            hold_q <= in_data;
            tgt_q  <= nxt_idx;
            ptr_q  <= ptr_after;
        end
    end

    // Count completed output transfers, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (xfer) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // One-hot valid on the target channel while a word is held.
    always_comb begin
        out_valid = '0;
        if (state_q == FULL) begin
            out_valid[tgt_q] = 1'b1;
        end
    end

    assign sel            = tgt_q;
    assign dispatch_count = count_q;

    my_dmux_n #(
        .N     (N_OUT),
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_dmux (
        .din  (hold_q),
        .sel  (tgt_q),
        .en   (state_q == FULL),
        .dout (out_data)
    );

endmodule

// File: tb/tb_my_dmux_rr_dispatch.sv
// Directed bench for my_dmux_rr_dispatch. Stimulus pushes the expected delivery of every accepted
// word, and a monitor pops and compares each word as a channel takes it.
module tb_my_dmux_rr_dispatch;

    localparam int unsigned N_OUT = 2;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    typedef struct {
        int unsigned      ch;
        logic [WIDTH-1:0] d;
    } exp_t;

    logic                   clk;
    logic                   rst;
    logic [WIDTH-1:0]       in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_OUT-1:0]       ch_en;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic [0:0]             sel;
    logic [CNT_W-1:0]       dispatch_count;

    exp_t exp_q[$];
    int   n_pass;
    int   n_total;

    my_dmux_rr_dispatch #(
        .N_OUT (N_OUT),
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .ch_en          (ch_en),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .sel            (sel),
        .dispatch_count (dispatch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present a word and wait (bounded) for in_ready. The expected delivery is queued, then the
    // task returns 1 ns after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] d, input int unsigned ch, output int waits);
        logic ok;
        exp_t e;
        ok       = 1'b0;
        waits    = 0;
        in_data  = d;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        if (!ok) begin
            check("send_timeout", 64'(waits), 64'(0));
            in_valid = 1'b0;
        end else begin
            e.ch = ch;
            e.d  = d;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Monitor: every handshake on an output channel consumes one expected delivery.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 64'(i), 64'hFFFF);
                    end else begin
                        exp_t e;
                        logic [N_OUT*WIDTH-1:0] exp_data;
                        e        = exp_q.pop_front();
                        exp_data = '0;
                        exp_data[e.ch*WIDTH +: WIDTH] = e.d;
                        check("mon_channel", 64'(i), 64'(e.ch));
                        check("mon_out_valid", 64'(out_valid), 64'(1 << e.ch));
                        check("mon_out_data", 64'(out_data), 64'(exp_data));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int stalls;
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        ch_en     = 2'b11;
        out_ready = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_sel", 64'(sel), 64'(0));
        check("rst_count", 64'(dispatch_count), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // 1: a reset asserted mid-hold discards the word.
        send(8'hA5, 0, w);
        check("t1_held_valid", 64'(out_valid), 64'(2'b01));
        check("t1_held_data", 64'(out_data), 64'(16'h00A5));
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("t1_rst_valid", 64'(out_valid), 64'(0));
        check("t1_rst_data", 64'(out_data), 64'(0));
        check("t1_rst_count", 64'(dispatch_count), 64'(0));
        rst = 1'b0;
        #1;
        check("t1_in_ready", 64'(in_ready), 64'(1));

        // 2: round-robin with both channels enabled and ready.
        out_ready = 2'b11;
        stalls    = 0;
        send(8'h11, 0, w); stalls += w;
        send(8'h22, 1, w); stalls += w;
        send(8'h33, 0, w); stalls += w;
        send(8'h44, 1, w); stalls += w;
        check("t2_no_stall", 64'(stalls), 64'(0));
        @(posedge clk);
        #1;
        check("t2_count", 64'(dispatch_count), 64'(4));
        check("t2_empty", 64'(out_valid), 64'(0));

        // 3: backpressure holds the word stable and blocks input.
        out_ready = 2'b00;
        send(8'h5A, 0, w);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_valid", 64'(out_valid), 64'(2'b01));
            check("t3_data", 64'(out_data), 64'(16'h005A));
            check("t3_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 2'b01;
        @(posedge clk);
        #1;
        check("t3_count", 64'(dispatch_count), 64'(5));
        check("t3_empty", 64'(out_valid), 64'(0));

        // 4: a disabled channel is skipped, and clearing ch_en leaves the held word targeted.
        out_ready = 2'b00;
        ch_en     = 2'b10;
        send(8'h01, 1, w);
        check("t4_sel_a", 64'(sel), 64'(1));
        check("t4_valid_a", 64'(out_valid), 64'(2'b10));
        out_ready = 2'b10;
        send(8'h02, 1, w);
        out_ready = 2'b00;
        ch_en     = 2'b00;
        #1;
        check("t4_sel_b", 64'(sel), 64'(1));
        check("t4_valid_b", 64'(out_valid), 64'(2'b10));
        check("t4_in_ready_stall", 64'(in_ready), 64'(0));
        out_ready = 2'b10;
        @(posedge clk);
        #1;
        check("t4_count", 64'(dispatch_count), 64'(7));
        check("t4_in_ready_after", 64'(in_ready), 64'(0));
        check("t4_empty", 64'(out_valid), 64'(0));
        check("t4_sel_kept", 64'(sel), 64'(1));

        // 5: drain and refill complete in the same cycle.
        out_ready = 2'b00;
        ch_en     = 2'b11;
        send(8'h66, 0, w);
        out_ready = 2'b01;
        send(8'h77, 1, w);
        out_ready = 2'b00;
        #1;
        check("t5_valid", 64'(out_valid), 64'(2'b10));
        check("t5_data", 64'(out_data), 64'(16'h7700));
        check("t5_count", 64'(dispatch_count), 64'(8));
        out_ready = 2'b11;
        @(posedge clk);
        #1;
        check("t5_count_after", 64'(dispatch_count), 64'(9));

        // 6: 17 transfers from reset wrap the 4-bit counter to 1.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        check("t6_rst_count", 64'(dispatch_count), 64'(0));
        for (int k = 0; k < 17; k++) begin
            logic [WIDTH-1:0] d;
            d = WIDTH'(8'h80 + k);
            send(d, k % 2, w);
        end
        @(posedge clk);
        #1;
        check("t6_count_wrap", 64'(dispatch_count), 64'(1));
        check("t6_queue_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
